// File: rtl/ysyx_22050019_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22050019_arb_pkg
// Purpose : Shared definitions for the two-master AXI-lite read arbiter:
//           FSM state encoding, one-hot grant constants, response codes.
// Ports   : none (package)
// Config  : YSYX_22050019_ARB_RR_EN selects round-robin in the picker.
// Revision: 1.0 - initial release
// ============================================================================
package ysyx_22050019_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } arb_state_t;

  // One-hot grant encoding, bit order {m1, m0}
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage
`default_nettype wire

// File: rtl/ysyx_22050019_arb_pick.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22050019_arb_pick
// Purpose : Combinational winner selection for the read arbiter.
// Ports   : req        [1:0] in  - pending requests {m1, m0}
//           last_grant [1:0] in  - one-hot owner of the last completed read
//           win        [1:0] out - one-hot winner, 0 when no request
// Config  : YSYX_22050019_ARB_RR_EN defined -> round-robin on ties,
//           otherwise fixed priority m1 > m0.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_22050019_arb_pick
  import ysyx_22050019_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] win
);

`ifdef YSYX_22050019_ARB_RR_EN
  // On a tie the master that did not own the last read wins; a lone
  // requester always wins.
  always_comb begin
    win = GRANT_NONE;
    if (req == 2'b11) begin
      win = (last_grant == GRANT_M1) ? GRANT_M0 : GRANT_M1;
    end else if (req[1]) begin
      win = GRANT_M1;
    end else if (req[0]) begin
      win = GRANT_M0;
    end
  end
`else
  // Fixed priority: LSU (m1) ahead of IFU (m0). History is not consulted.
  logic w_unused_last_grant;
  assign w_unused_last_grant = ^last_grant;

  always_comb begin
    win = GRANT_NONE;
    if (req[1]) begin
      win = GRANT_M1;
    end else if (req[0]) begin
      win = GRANT_M0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/ysyx_22050019_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22050019_axi_rd_arbiter
// Purpose : Two-master / one-slave AXI-lite read arbiter. Sequences one
//           single-beat read at a time (AR then R) from the fetch buffer (m0)
//           or the LSU (m1) and routes the response to the granted master.
// Ports   : clk, rst_n (synchronous, active-high despite the name)
//           m0_*/m1_*  : master AR (valid/addr/ready) and R (valid/data/
//                        resp/ready) channels
//           s_*        : slave AR and R channels
//           grant_o    : one-hot owner {m1,m0}, 0 in IDLE
//           err_o      : sticky, set on any non-OKAY response
// Config  : YSYX_22050019_ARB_RR_EN -> round-robin arbitration (else m1 > m0)
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_22050019_axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_ar_valid_i,
  input  logic [ADDR_W-1:0] m0_ar_addr_i,
  output logic              m0_ar_ready_o,
  output logic              m0_r_valid_o,
  output logic [DATA_W-1:0] m0_r_data_o,
  output logic [1:0]        m0_r_resp_o,
  input  logic              m0_r_ready_i,

  input  logic              m1_ar_valid_i,
  input  logic [ADDR_W-1:0] m1_ar_addr_i,
  output logic              m1_ar_ready_o,
  output logic              m1_r_valid_o,
  output logic [DATA_W-1:0] m1_r_data_o,
  output logic [1:0]        m1_r_resp_o,
  input  logic              m1_r_ready_i,

  output logic              s_ar_valid_o,
  output logic [ADDR_W-1:0] s_ar_addr_o,
  input  logic              s_ar_ready_i,
  input  logic              s_r_valid_i,
  input  logic [DATA_W-1:0] s_r_data_i,
  input  logic [1:0]        s_r_resp_i,
  output logic              s_r_ready_o,

  output logic [1:0]        grant_o,
  output logic              err_o
);

  import ysyx_22050019_arb_pkg::*;

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic [1:0] r_grant;
  logic [1:0] w_grant_nxt;
  logic [1:0] r_last_grant;
  logic [1:0] w_last_grant_nxt;
  logic       r_err;
  logic       w_err_nxt;

  logic [1:0] w_req;
  logic [1:0] w_win;
  logic       w_sel_ar_valid;
  logic       w_sel_r_ready;
  logic       w_r_hs;

  assign w_req = {m1_ar_valid_i, m0_ar_valid_i};

  ysyx_22050019_arb_pick u_pick (
    .req        (w_req),
    .last_grant (r_last_grant),
    .win        (w_win)
  );

  // Granted master's handshake inputs; grant is one-hot so AND-OR is a mux.
  assign w_sel_ar_valid = (r_grant[1] & m1_ar_valid_i) | (r_grant[0] & m0_ar_valid_i);
  assign w_sel_r_ready  = (r_grant[1] & m1_r_ready_i)  | (r_grant[0] & m0_r_ready_i);
  assign w_r_hs         = (r_state == ST_DATA) && s_r_valid_i && w_sel_r_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= GRANT_NONE;
      r_last_grant <= GRANT_M0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_err        <= w_err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_err_nxt        = r_err;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_state_nxt = ST_ADDR;
          w_grant_nxt = w_win;
        end
      end
      ST_ADDR: begin
        // A master withdrawing its request before the handshake (e.g. IFU
        // flush) releases the slot without touching the slave.
        if (!w_sel_ar_valid) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = GRANT_NONE;
        end else if (s_ar_ready_i) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_r_hs) begin
          w_state_nxt      = ST_IDLE;
          w_grant_nxt      = GRANT_NONE;
          w_last_grant_nxt = r_grant;
          if (s_r_resp_i != RESP_OKAY) begin
            w_err_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = GRANT_NONE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Channel routing. Everything is forced quiet while reset is asserted so no
  // handshake can complete in the reset cycle itself.
  // --------------------------------------------------------------------------
  always_comb begin
    s_ar_valid_o  = 1'b0;
    s_ar_addr_o   = '0;
    s_r_ready_o   = 1'b0;
    m0_ar_ready_o = 1'b0;
    m1_ar_ready_o = 1'b0;
    m0_r_valid_o  = 1'b0;
    m1_r_valid_o  = 1'b0;
    m0_r_data_o   = '0;
    m1_r_data_o   = '0;
    m0_r_resp_o   = 2'b00;
    m1_r_resp_o   = 2'b00;
    if (!rst_n) begin
      case (r_state)
        ST_ADDR: begin
          // Address is passed through live so a redirect before the
          // handshake reaches the slave.
          s_ar_valid_o  = w_sel_ar_valid;
          s_ar_addr_o   = r_grant[1] ? m1_ar_addr_i : m0_ar_addr_i;
          m0_ar_ready_o = r_grant[0] & s_ar_ready_i;
          m1_ar_ready_o = r_grant[1] & s_ar_ready_i;
        end
        ST_DATA: begin
          s_r_ready_o = w_sel_r_ready;
          if (r_grant[0]) begin
            m0_r_valid_o = s_r_valid_i;
            m0_r_data_o  = s_r_data_i;
            m0_r_resp_o  = s_r_resp_i;
          end
          if (r_grant[1]) begin
            m1_r_valid_o = s_r_valid_i;
            m1_r_data_o  = s_r_data_i;
            m1_r_resp_o  = s_r_resp_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign grant_o = r_grant;
  assign err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050019_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_22050019_axi_rd_arbiter
// Purpose : Directed self-checking bench for the AXI-lite read arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ysyx_22050019_axi_rd_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              m0_ar_valid_i, m1_ar_valid_i;
  logic [ADDR_W-1:0] m0_ar_addr_i, m1_ar_addr_i;
  logic              m0_ar_ready_o, m1_ar_ready_o;
  logic              m0_r_valid_o, m1_r_valid_o;
  logic [DATA_W-1:0] m0_r_data_o, m1_r_data_o;
  logic [1:0]        m0_r_resp_o, m1_r_resp_o;
  logic              m0_r_ready_i, m1_r_ready_i;
  logic              s_ar_valid_o;
  logic [ADDR_W-1:0] s_ar_addr_o;
  logic              s_ar_ready_i;
  logic              s_r_valid_i;
  logic [DATA_W-1:0] s_r_data_i;
  logic [1:0]        s_r_resp_i;
  logic              s_r_ready_o;
  logic [1:0]        grant_o;
  logic              err_o;

  int vectors     = 0;
  int miscompares = 0;

  ysyx_22050019_axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m0_ar_valid_i (m0_ar_valid_i),
    .m0_ar_addr_i  (m0_ar_addr_i),
    .m0_ar_ready_o (m0_ar_ready_o),
    .m0_r_valid_o  (m0_r_valid_o),
    .m0_r_data_o   (m0_r_data_o),
    .m0_r_resp_o   (m0_r_resp_o),
    .m0_r_ready_i  (m0_r_ready_i),
    .m1_ar_valid_i (m1_ar_valid_i),
    .m1_ar_addr_i  (m1_ar_addr_i),
    .m1_ar_ready_o (m1_ar_ready_o),
    .m1_r_valid_o  (m1_r_valid_o),
    .m1_r_data_o   (m1_r_data_o),
    .m1_r_resp_o   (m1_r_resp_o),
    .m1_r_ready_i  (m1_r_ready_i),
    .s_ar_valid_o  (s_ar_valid_o),
    .s_ar_addr_o   (s_ar_addr_o),
    .s_ar_ready_i  (s_ar_ready_i),
    .s_r_valid_i   (s_r_valid_i),
    .s_r_data_i    (s_r_data_i),
    .s_r_resp_i    (s_r_resp_i),
    .s_r_ready_o   (s_r_ready_o),
    .grant_o       (grant_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_ar_valid_i = 1'b0; m0_ar_addr_i = '0; m0_r_ready_i = 1'b0;
    m1_ar_valid_i = 1'b0; m1_ar_addr_i = '0; m1_r_ready_i = 1'b0;
    s_ar_ready_i  = 1'b0; s_r_valid_i  = 1'b0;
    s_r_data_i    = '0;   s_r_resp_i   = 2'b00;
  endtask

  // Stimulus only: from ADDR, accept the address and the response.
  task automatic finish_txn();
    s_ar_ready_i = 1'b1;
    step();
    s_ar_ready_i  = 1'b0;
    m0_ar_valid_i = 1'b0;
    m1_ar_valid_i = 1'b0;
    s_r_valid_i   = 1'b1;
    step();
    s_r_valid_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b1;
    step();
    step();
    vectors++; if (grant_o !== 2'b00) begin miscompares++; $display("FAIL reset_grant: got %b expected 00", grant_o); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err_o); end
    vectors++; if ({s_ar_valid_o, s_r_ready_o, m0_r_valid_o, m1_r_valid_o} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_valids: got %b expected 0000", {s_ar_valid_o, s_r_ready_o, m0_r_valid_o, m1_r_valid_o}); end
    rst_n = 1'b0;
    step();
    vectors++; if (s_ar_addr_o !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", s_ar_addr_o); end
  endtask

  task automatic test_single_m0();
    m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0000; m0_r_ready_i = 1'b1;
    step();
    vectors++; if (s_ar_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_ar_valid: got %b expected 1", s_ar_valid_o); end
    vectors++; if (s_ar_addr_o !== 32'h8000_0000) begin miscompares++; $display("FAIL single_ar_addr: got %h expected 80000000", s_ar_addr_o); end
    vectors++; if (grant_o !== 2'b01) begin miscompares++; $display("FAIL single_grant: got %b expected 01", grant_o); end
    vectors++; if (m0_ar_ready_o !== 1'b0) begin miscompares++; $display("FAIL single_ready_early: got %b expected 0", m0_ar_ready_o); end
    step();
    step();
    s_ar_ready_i = 1'b1;
    #1;
    vectors++; if ({m1_ar_ready_o, m0_ar_ready_o} !== 2'b01) begin miscompares++; $display("FAIL single_ar_ready: got %b expected 01", {m1_ar_ready_o, m0_ar_ready_o}); end
    step();
    s_ar_ready_i = 1'b0; m0_ar_valid_i = 1'b0;
    s_r_valid_i = 1'b1; s_r_data_i = 128'h0123; s_r_resp_i = 2'b00;
    #1;
    vectors++; if (s_ar_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_ar_in_data: got %b expected 0", s_ar_valid_o); end
    vectors++; if (m0_r_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_r_valid: got %b expected 1", m0_r_valid_o); end
    vectors++; if (m0_r_data_o !== 128'h0123) begin miscompares++; $display("FAIL single_r_data: got %h expected 0123", m0_r_data_o); end
    vectors++; if ({m1_r_valid_o, m1_r_data_o} !== {1'b0, 128'h0}) begin miscompares++; $display("FAIL single_other_quiet: got %b/%h expected 0/0", m1_r_valid_o, m1_r_data_o); end
    vectors++; if (s_r_ready_o !== 1'b1) begin miscompares++; $display("FAIL single_r_ready: got %b expected 1", s_r_ready_o); end
    step();
    s_r_valid_i = 1'b0; s_r_data_i = '0;
    #1;
    vectors++; if (grant_o !== 2'b00) begin miscompares++; $display("FAIL single_idle_grant: got %b expected 00", grant_o); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL single_err: got %b expected 0", err_o); end
  endtask

  task automatic test_arbitration();
    logic [1:0]        exp_g [4];
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] got_data;
    logic              other_valid;
`ifdef YSYX_22050019_ARB_RR_EN
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
`else
    exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b10; exp_g[3] = 2'b10;
`endif
    m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0010; m0_r_ready_i = 1'b1;
    m1_ar_valid_i = 1'b1; m1_ar_addr_i = 32'h8000_1000; m1_r_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_addr = (exp_g[i] == 2'b10) ? 32'h8000_1000 : 32'h8000_0010;
      vectors++; if (grant_o !== exp_g[i]) begin miscompares++; $display("FAIL arb_grant[%0d]: got %b expected %b", i, grant_o, exp_g[i]); end
      vectors++; if (s_ar_addr_o !== exp_addr) begin miscompares++; $display("FAIL arb_addr[%0d]: got %h expected %h", i, s_ar_addr_o, exp_addr); end
      s_ar_ready_i = 1'b1;
      step();
      s_ar_ready_i = 1'b0;
      s_r_valid_i = 1'b1; s_r_data_i = 128'(i + 1);
      #1;
      got_data    = (exp_g[i] == 2'b10) ? m1_r_data_o : m0_r_data_o;
      other_valid = (exp_g[i] == 2'b10) ? m0_r_valid_o : m1_r_valid_o;
      vectors++; if (got_data !== 128'(i + 1)) begin miscompares++; $display("FAIL arb_data[%0d]: got %h expected %h", i, got_data, 128'(i + 1)); end
      vectors++; if (other_valid !== 1'b0) begin miscompares++; $display("FAIL arb_other_valid[%0d]: got %b expected 0", i, other_valid); end
      step();
      s_r_valid_i = 1'b0;
      #1;
      vectors++; if (grant_o !== 2'b00) begin miscompares++; $display("FAIL arb_idle[%0d]: got %b expected 00", i, grant_o); end
    end
    m1_ar_valid_i = 1'b0;
    step();
    vectors++; if (grant_o !== 2'b01) begin miscompares++; $display("FAIL arb_m0_after: got %b expected 01", grant_o); end
    finish_txn();
  endtask

  task automatic test_addr_redirect();
    m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0020;
    step();
    vectors++; if (s_ar_addr_o !== 32'h8000_0020) begin miscompares++; $display("FAIL redir_first: got %h expected 80000020", s_ar_addr_o); end
    m0_ar_addr_i = 32'h8000_0100;
    step();
    s_ar_ready_i = 1'b1;
    #1;
    vectors++; if (s_ar_addr_o !== 32'h8000_0100) begin miscompares++; $display("FAIL redir_at_hs: got %h expected 80000100", s_ar_addr_o); end
    vectors++; if ({s_ar_valid_o, m0_ar_ready_o} !== 2'b11) begin miscompares++; $display("FAIL redir_hs: got %b expected 11", {s_ar_valid_o, m0_ar_ready_o}); end
    finish_txn();
  endtask

  task automatic test_error();
    m1_ar_valid_i = 1'b1; m1_ar_addr_i = 32'h8000_2000;
    step();
    vectors++; if (grant_o !== 2'b10) begin miscompares++; $display("FAIL err_grant: got %b expected 10", grant_o); end
    s_ar_ready_i = 1'b1;
    step();
    s_ar_ready_i = 1'b0; m1_ar_valid_i = 1'b0;
    s_r_valid_i = 1'b1; s_r_resp_i = 2'b10;
    #1;
    vectors++; if (m1_r_resp_o !== 2'b10) begin miscompares++; $display("FAIL err_m1_resp: got %b expected 10", m1_r_resp_o); end
    vectors++; if (m0_r_resp_o !== 2'b00) begin miscompares++; $display("FAIL err_m0_resp: got %b expected 00", m0_r_resp_o); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL err_early: got %b expected 0", err_o); end
    step();
    s_r_valid_i = 1'b0; s_r_resp_i = 2'b00;
    #1;
    vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b expected 1", err_o); end
    m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0040;
    step();
    finish_txn();
    vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b expected 1", err_o); end
  endtask

  task automatic test_reset_mid();
    m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_3000;
    step();
    s_ar_ready_i = 1'b1;
    step();
    s_ar_ready_i = 1'b0; m0_ar_valid_i = 1'b0; s_r_valid_i = 1'b0;
    #1;
    vectors++; if ({grant_o, s_r_ready_o} !== 3'b011) begin miscompares++; $display("FAIL rstmid_data: got %b expected 011", {grant_o, s_r_ready_o}); end
    rst_n = 1'b1;
    #1;
    vectors++; if (s_r_ready_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready_gated: got %b expected 0", s_r_ready_o); end
    step();
    rst_n = 1'b0;
    #1;
    vectors++; if (grant_o !== 2'b00) begin miscompares++; $display("FAIL rstmid_grant: got %b expected 00", grant_o); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_err: got %b expected 0", err_o); end
    vectors++; if ({s_ar_valid_o, s_r_ready_o, m0_r_valid_o, m1_r_valid_o} !== 4'b0000) begin
      miscompares++; $display("FAIL rstmid_valids: got %b expected 0000", {s_ar_valid_o, s_r_ready_o, m0_r_valid_o, m1_r_valid_o}); end
    m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_4000;
    step();
    vectors++; if ({grant_o, s_ar_valid_o} !== 3'b011) begin miscompares++; $display("FAIL rstmid_regrant: got %b expected 011", {grant_o, s_ar_valid_o}); end
    s_ar_ready_i = 1'b1;
    step();
    s_ar_ready_i = 1'b0; m0_ar_valid_i = 1'b0;
    s_r_valid_i = 1'b1; s_r_data_i = 128'hABCD;
    #1;
    vectors++; if (m0_r_data_o !== 128'hABCD) begin miscompares++; $display("FAIL rstmid_data_after: got %h expected abcd", m0_r_data_o); end
    step();
    s_r_valid_i = 1'b0;
  endtask

  task automatic test_drop();
    // last owner is m0 here, so m1 wins the tie in both arbitration modes
    m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_5000;
    m1_ar_valid_i = 1'b1; m1_ar_addr_i = 32'h8000_6000;
    step();
    vectors++; if (grant_o !== 2'b10) begin miscompares++; $display("FAIL drop_grant: got %b expected 10", grant_o); end
    m1_ar_valid_i = 1'b0;
    #1;
    vectors++; if (s_ar_valid_o !== 1'b0) begin miscompares++; $display("FAIL drop_ar_valid: got %b expected 0", s_ar_valid_o); end
    step();
    vectors++; if (grant_o !== 2'b00) begin miscompares++; $display("FAIL drop_idle: got %b expected 00", grant_o); end
    step();
    vectors++; if (grant_o !== 2'b01) begin miscompares++; $display("FAIL drop_m0_grant: got %b expected 01", grant_o); end
    vectors++; if (s_ar_addr_o !== 32'h8000_5000) begin miscompares++; $display("FAIL drop_m0_addr: got %h expected 80005000", s_ar_addr_o); end
    finish_txn();
  endtask

  initial begin
    test_reset();
    test_single_m0();
    test_arbitration();
    test_addr_redirect();
    test_error();
    test_reset_mid();
    test_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
